// File: rtl/decode_sequencer.sv
// Registered instruction decoder that walks the register-file operand sequence of each
// accepted 16-bit instruction. Optional macro DECODE_SEQ_PIPE_EN: accept in DONE for back-to-back sequences.
module decode_sequencer #(
  parameter int DATA_W       = 16,
  parameter int ILLEGAL_HALT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              step_en,
  output logic [2:0]        readnum,
  output logic              rd_valid,
  output logic [2:0]        writenum,
  output logic              wr_valid,
  output logic [1:0]        nsel,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output logic              done,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {
    IDLE,
    STEP1,
    STEP2,
    STEP3,
    DONE,
    HALT
  } state_e;

  // Step descriptor: {read, write, nsel}; nsel 00 Rn, 01 Rd, 10 Rm, 11 none.
  localparam logic [3:0] STEP_NONE = 4'b0011;
  localparam logic [3:0] RD_RN     = 4'b1000;
  localparam logic [3:0] RD_RD     = 4'b1001;
  localparam logic [3:0] RD_RM     = 4'b1010;
  localparam logic [3:0] WR_RN     = 4'b0100;
  localparam logic [3:0] WR_RD     = 4'b0101;

  function automatic logic [3:0] stepOf(input logic [15:0] ins, input logic [1:0] idx);
    logic [3:0] s0;
    logic [3:0] s1;
    logic [3:0] s2;
    s0 = STEP_NONE;
    s1 = STEP_NONE;
    s2 = STEP_NONE;
    case (ins[15:13])
      3'b011: begin
        s0 = RD_RN;
        s1 = WR_RD;
      end
      3'b100: begin
        s0 = RD_RN;
        s1 = RD_RD;
      end
      3'b101: begin
        case (ins[12:11])
          2'b01: begin
            s0 = RD_RN;
            s1 = RD_RM;
          end
          2'b11: begin
            s0 = RD_RM;
            s1 = WR_RD;
          end
          default: begin
            s0 = RD_RN;
            s1 = RD_RM;
            s2 = WR_RD;
          end
        endcase
      end
      3'b110: begin
        case (ins[12:11])
          2'b10: s0 = WR_RN;
          2'b00: begin
            s0 = RD_RM;
            s1 = WR_RD;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    case (idx)
      2'd0:    return s0;
      2'd1:    return s1;
      2'd2:    return s2;
      default: return STEP_NONE;
    endcase
  endfunction

  function automatic logic isIllegalOp(input logic [15:0] ins);
    return (ins[15:13] inside {3'b000, 3'b001, 3'b010}) ||
           ((ins[15:13] == 3'b110) && ins[11]);
  endfunction

  function automatic logic isHaltOp(input logic [15:0] ins);
    return ins[15:13] == 3'b111;
  endfunction

  function automatic state_e entryState(input logic [15:0] ins);
    if (isHaltOp(ins)) return HALT;
    if (isIllegalOp(ins)) return (ILLEGAL_HALT != 0) ? HALT : DONE;
    return STEP1;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        illegal_q, illegal_d;

  logic [1:0]  stepIdx;
  logic        stepActive;
  logic [3:0]  curStep;
  logic        lastStep;
  logic [2:0]  fieldReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      instr_q   <= 16'h0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      illegal_q <= illegal_d;
    end
  end

  // An accept overrides the per-state transition; in_ready limits it to IDLE (or DONE when pipelined).
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    illegal_d = 1'b0;
    case (state_q)
      STEP1, STEP2, STEP3: begin
        if (step_en) begin
          if (lastStep) state_d = DONE;
          else if (state_q == STEP1) state_d = STEP2;
          else state_d = STEP3;
        end
      end
      DONE:    state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (in_valid && in_ready) begin
      state_d   = entryState(instr);
      instr_d   = instr;
      illegal_d = isIllegalOp(instr);
    end
  end

  always_comb begin
    stepIdx    = 2'd0;
    stepActive = 1'b0;
    case (state_q)
      STEP1: begin
        stepIdx    = 2'd0;
        stepActive = 1'b1;
      end
      STEP2: begin
        stepIdx    = 2'd1;
        stepActive = 1'b1;
      end
      STEP3: begin
        stepIdx    = 2'd2;
        stepActive = 1'b1;
      end
      default: ;
    endcase
    curStep  = stepActive ? stepOf(instr_q, stepIdx) : STEP_NONE;
    lastStep = (stepOf(instr_q, stepIdx + 2'd1) == STEP_NONE);
    case (curStep[1:0])
      2'b00:   fieldReg = instr_q[10:8];
      2'b01:   fieldReg = instr_q[7:5];
      2'b10:   fieldReg = instr_q[2:0];
      default: fieldReg = 3'd0;
    endcase
`ifdef DECODE_SEQ_PIPE_EN
    in_ready = (state_q == IDLE) || (state_q == DONE);
`else
    in_ready = (state_q == IDLE);
`endif
  end

  assign rd_valid = curStep[3];
  assign wr_valid = curStep[2];
  assign nsel     = curStep[1:0];
  assign readnum  = rd_valid ? fieldReg : 3'd0;
  assign writenum = wr_valid ? fieldReg : 3'd0;

  assign done    = (state_q == DONE);
  assign halted  = (state_q == HALT);
  assign illegal = illegal_q;

  assign opcode = instr_q[15:13];
  assign op     = instr_q[12:11];
  assign shift  = instr_q[4:3];
  assign sximm5 = {{(DATA_W-5){instr_q[4]}}, instr_q[4:0]};
  assign sximm8 = {{(DATA_W-8){instr_q[7]}}, instr_q[7:0]};

endmodule

// File: tb/tb_decode_sequencer.sv
// Scoreboard bench for decode_sequencer: a plan-based reference model queues expected
// operand steps and end events; a negedge monitor pops and compares them.
module tb_decode_sequencer;

  localparam int DW = 32;
`ifdef DECODE_SEQ_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  localparam int K_RD = 0;
  localparam int K_WR = 1;
  localparam int K_DONE = 2;
  localparam int K_HALT = 3;

  typedef struct {
    int         kind;
    logic [2:0] regNum;
    logic [1:0] nselExp;
    logic       ill;
    logic [2:0] opc;
    logic [1:0] opx;
    logic [1:0] sh;
    logic [31:0] sx5;
    logic [31:0] sx8;
  } evt_t;

  logic          clk;
  logic          reset;
  logic [15:0]   instr;
  logic          in_valid;
  logic          in_ready;
  logic          step_en;
  logic [2:0]    readnum;
  logic          rd_valid;
  logic [2:0]    writenum;
  logic          wr_valid;
  logic [1:0]    nsel;
  logic [2:0]    opcode;
  logic [1:0]    op;
  logic [1:0]    shift;
  logic [DW-1:0] sximm5;
  logic [DW-1:0] sximm8;
  logic          done;
  logic          halted;
  logic          illegal;

  evt_t expQ[$];
  int   nTests = 0;
  int   nFail = 0;
  bit   haltSeen = 1'b0;
  bit   autoStep = 1'b1;
  bit   randomStall = 1'b0;
  bit   lastAcceptDone = 1'b0;

  decode_sequencer #(.DATA_W(DW), .ILLEGAL_HALT(0)) dut (
    .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
    .step_en(step_en), .readnum(readnum), .rd_valid(rd_valid), .writenum(writenum),
    .wr_valid(wr_valid), .nsel(nsel), .opcode(opcode), .op(op), .shift(shift),
    .sximm5(sximm5), .sximm8(sximm8), .done(done), .halted(halted), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // step_en is normally owned here; directed tests clear autoStep to drive it themselves
  initial begin
    step_en = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (autoStep) step_en = randomStall ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each instruction class is an operand plan, two characters per step
  task automatic modelPush(input logic [15:0] ins);
    string plan;
    bit    isIll;
    bit    isHalt;
    evt_t  e;
    int    v5;
    int    v8;
    isIll  = 1'b0;
    isHalt = 1'b0;
    plan   = "";
    case (ins[15:13])
      3'b111: isHalt = 1'b1;
      3'b011: plan = "RnWd";
      3'b100: plan = "RnRd";
      3'b101: begin
        if (ins[12:11] == 2'b01) plan = "RnRm";
        else if (ins[12:11] == 2'b11) plan = "RmWd";
        else plan = "RnRmWd";
      end
      3'b110: begin
        if (ins[12:11] == 2'b10) plan = "Wn";
        else if (ins[12:11] == 2'b00) plan = "RmWd";
        else isIll = 1'b1;
      end
      default: isIll = 1'b1;
    endcase
    v5 = $signed(ins[4:0]);
    v8 = $signed(ins[7:0]);
    e.opc = ins[15:13];
    e.opx = ins[12:11];
    e.sh  = ins[4:3];
    e.sx5 = v5;
    e.sx8 = v8;
    e.ill = 1'b0;
    e.regNum = 3'd0;
    e.nselExp = 2'b11;
    for (int i = 0; i < plan.len(); i += 2) begin
      e.kind = (plan[i] == "R") ? K_RD : K_WR;
      if (plan[i+1] == "n") begin
        e.regNum = ins[10:8];
        e.nselExp = 2'b00;
      end else if (plan[i+1] == "d") begin
        e.regNum = ins[7:5];
        e.nselExp = 2'b01;
      end else begin
        e.regNum = ins[2:0];
        e.nselExp = 2'b10;
      end
      expQ.push_back(e);
    end
    e.regNum = 3'd0;
    e.nselExp = 2'b11;
    e.ill = isIll;
    e.kind = isHalt ? K_HALT : K_DONE;
    expQ.push_back(e);
  endtask

  task automatic checkFields(input evt_t e);
    checkOutput("fields", 128'({opcode, op, shift, sximm5, sximm8}),
                128'({e.opc, e.opx, e.sh, e.sx5, e.sx8}));
  endtask

  // Monitor: pops an expected event whenever the DUT presents a step, end or halt
  initial begin
    evt_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rd_valid || wr_valid) begin
          if (expQ.size() == 0) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL spurious_step: got rd=%0b wr=%0b, expected no step", rd_valid, wr_valid);
          end else begin
            e = expQ[0];
            checkOutput("step", 128'({rd_valid, wr_valid, (rd_valid ? readnum : writenum), nsel}),
                        128'({(e.kind == K_RD), (e.kind == K_WR), e.regNum, e.nselExp}));
            checkOutput("unused_num", 128'(rd_valid ? writenum : readnum), 128'(0));
            checkFields(e);
            if (step_en) void'(expQ.pop_front());
          end
        end else if (done || illegal) begin
          if (expQ.size() == 0) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL spurious_end: got done=%0b illegal=%0b, expected none", done, illegal);
          end else begin
            e = expQ.pop_front();
            checkOutput("end", 128'({done, illegal, nsel, in_ready}),
                        128'({(e.kind == K_DONE), e.ill, 2'b11, PIPE}));
            checkFields(e);
          end
        end else if (halted && !haltSeen) begin
          haltSeen = 1'b1;
          if (expQ.size() == 0) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL spurious_halt: got halted=1, expected 0");
          end else begin
            e = expQ.pop_front();
            checkOutput("halt", 128'({halted, illegal, in_ready}), 128'({(e.kind == K_HALT), e.ill, 1'b0}));
          end
        end else begin
          checkOutput("quiet", 128'({readnum, writenum, nsel, halted}), 128'({3'd0, 3'd0, 2'b11, haltSeen}));
        end
      end
    end
  end

  // Offers one instruction and holds it until the DUT accepts it (bounded)
  task automatic applyStimulus(input logic [15:0] ins);
    int guard;
    bit ok;
    guard = 0;
    ok = 1'b0;
    @(posedge clk);
    #2;
    instr = ins;
    in_valid = 1'b1;
    while (!ok && guard < 100) begin
      @(negedge clk);
      if (in_ready) begin
        lastAcceptDone = done;
        modelPush(ins);
        ok = 1'b1;
      end
      guard++;
    end
    if (ok) begin
      @(posedge clk);
      #2;
    end else begin
      nTests++;
      nFail++;
      $display("[TB] FAIL accept_timeout: got no accept for %h, expected accept", ins);
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while ((expQ.size() != 0 || !in_ready) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain", 128'(expQ.size()), 128'(0));
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    expQ.delete();
    haltSeen = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int   cyc;
    logic [15:0] r;
    reset = 1'b1;
    instr = 16'h0000;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_state",
      128'({in_ready, rd_valid, wr_valid, readnum, writenum, nsel, done, halted, illegal,
            opcode, op, shift, sximm5, sximm8}),
      128'({1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 2'b11, 1'b0, 1'b0, 1'b0,
            3'd0, 2'd0, 2'd0, 32'd0, 32'd0}));

    // ADD R3,R1,R2: done exactly four cycles after the accept edge, then ready again
    applyStimulus(16'hA162);
    cyc = 0;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (done) break;
    end
    checkOutput("add_done_latency", 128'(cyc), 128'(4));
    @(negedge clk);
    checkOutput("add_ready_after", 128'(in_ready), 128'(1));

    // MOV R5,#-3
    applyStimulus(16'hD5FD);
    @(negedge clk);
    checkOutput("mov_imm", 128'({sximm8, wr_valid, writenum, nsel}), 128'({32'hFFFFFFFD, 1'b1, 3'd5, 2'b00}));
    waitDrain();

    // CMP R1,R2 stalled three cycles in its first step
    applyStimulus(16'hA902);
    autoStep = 1'b0;
    #1;
    step_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("cmp_stall", 128'({rd_valid, readnum, nsel}), 128'({1'b1, 3'd1, 2'b00}));
      if (k == 2) begin
        @(posedge clk);
        #1;
        step_en = 1'b1;
      end
    end
    autoStep = 1'b1;
    waitDrain();

    // Illegal opcode 000
    applyStimulus(16'h0123);
    @(negedge clk);
    checkOutput("illegal_pulse", 128'({illegal, done}), 128'(2'b11));
    @(negedge clk);
    checkOutput("illegal_after", 128'({in_ready, done, illegal}), 128'(3'b100));

    // Reset during the second step of an LDR
    applyStimulus(16'h6140);
    @(posedge clk);
    #3;
    reset = 1'b1;
    expQ.delete();
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_mid_seq", 128'({in_ready, rd_valid, wr_valid, done, nsel}), 128'({1'b1, 1'b0, 1'b0, 1'b0, 2'b11}));

    // HALT is sticky and refuses new work until reset
    applyStimulus(16'hE000);
    instr = 16'hA162;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("halt_hold", 128'({in_ready, halted}), 128'(2'b01));
    end
    in_valid = 1'b0;
    pulseReset();
    @(negedge clk);
    checkOutput("halt_reset", 128'({in_ready, halted}), 128'(2'b10));

    // Two LDRs offered back-to-back
    applyStimulus(16'h6140);
    applyStimulus(16'h6760);
    checkOutput("b2b_accept_in_done", 128'(lastAcceptDone), 128'(PIPE));
    @(negedge clk);
    checkOutput("b2b_step1", 128'({rd_valid, readnum}), 128'({1'b1, 3'd7}));
    waitDrain();

    // Randomized stream with random stalls; HALT is excluded since it needs a reset
    randomStall = 1'b1;
    for (int n = 0; n < 60; n++) begin
      r = 16'($urandom);
      if (r[15:13] == 3'b111) r[15:13] = 3'b101;
      applyStimulus(r);
    end
    waitDrain();
    randomStall = 1'b0;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/decode_sequencer.md
Name: decode_sequencer

Overview:
- Parametrised, registered successor to the combinational instruction decoder in the simple RISC datapath.
- Accepts a 16-bit instruction over a valid/ready handshake and latches it.
- Walks the register-operand sequence the instruction needs, one register-file access per cycle, driving readnum/writenum plus a select tag.
- Outputs DATA_W-wide sign-extended immediates. Flags HALT and illegal encodings.

Parameters:
- DATA_W, 16, width of sximm5/sximm8 outputs; legal range is 16 or more.
- ILLEGAL_HALT, 0, 1 = an illegal opcode behaves as HALT; 0 = illegal opcode pulses illegal and returns to IDLE.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instr  in  16  instruction word
- in_valid  in  1  instr is valid
- in_ready  out  1  block can accept instr
- step_en  in  1  datapath ready for the current operand step; 0 stalls the sequence
- readnum  out  3  register to read (valid while rd_valid)
- rd_valid  out  1  read step active
- writenum  out  3  register to write (valid while wr_valid)
- wr_valid  out  1  write step active
- nsel  out  2  active field: 00 Rn, 01 Rd, 10 Rm, 11 none
- opcode  out  3  latched instr[15:13]
- op  out  2  latched instr[12:11]; ALUop is the same field
- shift  out  2  latched instr[4:3]
- sximm5  out  DATA_W  sign extension of latched instr[4:0]
- sximm8  out  DATA_W  sign extension of latched instr[7:0]
- done  out  1  one-cycle pulse, sequence complete
- halted  out  1  HALT reached; sticky
- illegal  out  1  one-cycle pulse, illegal opcode

Behaviour:
- Fields: Rn = [10:8], Rd = [7:5], Rm = [2:0].
- States: IDLE, STEP1, STEP2, STEP3, DONE, HALT.
- Reset: state IDLE; latched instr = 0; all outputs 0 except in_ready = 1 and nsel = 11.
- Reset asserted mid-sequence or in HALT returns to IDLE on that edge.
- in_ready = 1 only in IDLE. A transfer occurs when in_valid & in_ready at the rising edge. The first step is visible in the next cycle (latency 1).
- Operand sequence (R = read, W = write):
  - 110/10 MOV imm: W Rn.
  - 110/00 MOV reg: R Rm, W Rd.
  - 101/00 ADD and 101/10 AND: R Rn, R Rm, W Rd.
  - 101/01 CMP: R Rn, R Rm.
  - 101/11 MVN: R Rm, W Rd.
  - 011 LDR: R Rn, W Rd.
  - 100 STR: R Rn, R Rd.
  - 111 HALT: no steps.
  - 000, 001, 010, and 110 with op 01 or 11: illegal.
- Step states use only as many of STEP1..STEP3 as the sequence needs.
  - rd_valid/readnum or wr_valid/writenum, plus nsel, are driven from the state and the latched instruction (Moore outputs).
  - The state advances only when step_en = 1. Otherwise the state and all outputs hold.
- After the last step the block enters DONE: done = 1 for one cycle, then IDLE.
- HALT: from IDLE enters HALT; halted = 1 and in_ready = 0 until reset.
- Illegal opcode, ILLEGAL_HALT = 0: goes to DONE with illegal = 1 and done = 1 in the same cycle, no steps.
- Illegal opcode, ILLEGAL_HALT = 1: goes to HALT with illegal pulsed in the first HALT cycle.
- Immediates: sign bit replicated to DATA_W. Field outputs are updated only at an accept edge and are stable for the whole sequence.
- readnum = 0 when rd_valid = 0; writenum = 0 when wr_valid = 0.

Optional Feature:
- Macro DECODE_SEQ_PIPE_EN.
- Defined: in_ready is also 1 in DONE. An instruction accepted in DONE goes directly to its STEP1 (or HALT/DONE), giving back-to-back sequences with no IDLE bubble. done still pulses.
- Undefined: in_ready = 1 only in IDLE, so there is a one-cycle IDLE gap between instructions.

Test Plan:
- ADD R3,R1,R2 (16'hA162), step_en = 1 → cycle +1 rd readnum = 1, nsel = 00; +2 rd readnum = 2, nsel = 10; +3 wr writenum = 3, nsel = 01; +4 done = 1; +5 in_ready = 1.
- MOV R5,#-3 (16'hD5FD), DATA_W = 32 → sximm8 = 32'hFFFFFFFD; one write step with writenum = 5, nsel = 00; then done.
- CMP R1,R2 with step_en held 0 for 3 cycles in STEP1 → readnum = 1 held for 4 cycles total; no wr_valid ever; done after STEP2.
- HALT (16'hE000) → halted = 1 from the next cycle; in_ready stays 0 while in_valid is held high for 10 cycles; reset → in_ready = 1 and halted = 0.
- Opcode 000 with ILLEGAL_HALT = 0 → illegal = 1 and done = 1 in the same cycle, then IDLE. Reset asserted during STEP2 of an LDR → next cycle IDLE, all strobes 0, nsel = 11.
- With DECODE_SEQ_PIPE_EN: two LDRs offered back-to-back → the second is accepted in the DONE cycle of the first, and its STEP1 immediately follows.
